trace_framer: RTL
=================

TRACE_FRAMER -- requirements
Module: trace_framer

Interface
REQ-001 SHALL have parameter SYNC_TIMEOUT, default 0, meaning the number of consecutive completed frames without a sync before sync is dropped (0 = never drop).
REQ-002 SHALL have port clk, input, 1 bit: system clock; every sequential element is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port din, input, 4 bits: one trace-port nibble already captured into the clk domain.
REQ-005 SHALL have port dinValid, input, 1 bit: din holds a new nibble this cycle.
REQ-006 SHALL have port frame, output, 128 bits: assembled TPIU frame.
REQ-007 SHALL have port frameValid, output, 1 bit: frame holds an undelivered frame.
REQ-008 SHALL have port frameReady, input, 1 bit: downstream accepts frame when frameValid and frameReady are both high.
REQ-009 SHALL have port synced, output, 1 bit: framer is aligned to the stream.
REQ-010 SHALL have port syncPulse, output, 1 bit: one-cycle pulse on every sync match.
REQ-011 SHALL have port ovfPulse, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-012 SHALL shift each valid nibble into a 32-bit window, entering at bits [31:28], with older nibbles moving toward bit 0.
REQ-013 SHALL detect a sync when the window equals 32'h7FFFFFFF after a valid nibble (stream f,f,f,f,f,f,f,7); detection SHALL work at any nibble position.
REQ-014 SHALL have exactly two states: UNSYNC and SYNC; synced SHALL be high only in SYNC.
REQ-015 SHALL, on a sync match in either state: enter SYNC, clear the nibble counter to 0, discard any partial frame, and pulse syncPulse in the cycle after the match nibble.
REQ-016 SHALL, in SYNC, write the k-th valid nibble after the sync into frame bits [4k+3:4k], for k = 0..31.
REQ-017 SHALL treat the nibbles of a detected sync pattern as sync only, never as frame data.
REQ-018 SHALL, when the 32nd nibble arrives, complete the frame, wrap the nibble counter to 0, and keep collecting with no new sync required.
REQ-019 SHALL have a single output holding register. A completed frame is loaded into it when the register is empty, or is being accepted in that same cycle.
REQ-020 SHALL assert frameValid one cycle after the 32nd nibble, and hold frame stable while frameValid is high and frameReady is low.
REQ-021 SHALL, when a frame completes while the holding register is full and not accepted that cycle, drop the new frame, keep the old one, and pulse ovfPulse.
REQ-022 SHALL, in UNSYNC, shift nibbles into the window and check for sync but assemble no frames.
REQ-023 SHALL, when SYNC_TIMEOUT is nonzero, count completed frames since the last sync and return to UNSYNC on reaching SYNC_TIMEOUT; the partial frame is discarded and a held frame is kept.
REQ-024 SHALL ignore din while dinValid is low; state, counters and window are unchanged.
REQ-025 SHALL keep a frame that is already held when sync is lost, until it is accepted.

Reset
REQ-026 SHALL, on rst: frame=0, frameValid=0, synced=0, syncPulse=0, ovfPulse=0, state UNSYNC, window=0, nibble counter=0, timeout counter=0.
REQ-027 SHALL, on rst asserted mid-frame or while a frame is held, discard all data; the first frame after reset requires a new sync.

Structure
REQ-028 SHALL place the constants SYNC_PATTERN (32'h7FFFFFFF), NIBBLES_PER_FRAME (32) and FRAME_BITS (128), and the state encoding, in the shared orbtrace package.
REQ-029 SHALL use one sub-module, trace_sync_detect (window shift register plus match comparator); the FSM, assembly and holding register SHALL stay in trace_framer.

Verification
REQ-030 Bench SHALL drive 16 nibbles of aa55aa55669966 99 with no sync -> no frameValid, synced=0.
REQ-031 Bench SHALL drive a sync then bytes 01 23 45 67 89 ab cd ef, twice, LSB nibble first, with frameReady=1 -> synced=1, one syncPulse, one frame = 128'hefcdab8967452301efcdab8967452301.
REQ-032 Bench SHALL drive a sync, bytes 01 23, then a full sync and frame -> the partial frame is discarded; exactly one frame, equal to the REQ-031 value.
REQ-033 Bench SHALL hold frameReady=0 while three frames complete after one sync -> the first frame is held unchanged, two ovfPulse pulses; on frameReady=1 the first frame is delivered.
REQ-034 Bench SHALL assert rst after 20 nibbles of a frame -> all outputs 0 immediately; the next frame requires a sync.
REQ-035 Bench SHALL use SYNC_TIMEOUT=2 and send three frames after one sync -> synced drops after frame 2, and frame 3 is not produced.

Source files
------------

// File: rtl/orbtrace_pkg.sv
// rtl/orbtrace_pkg.sv - shared TPIU trace framing constants and state encoding
//
// Purpose: constants and the framer state type used by trace_framer and
// trace_sync_detect.
// Contents:
//   SYNC_PATTERN      - window value that marks a full TPIU sync (f x7 then 7)
//   NIBBLES_PER_FRAME - nibbles assembled into one frame
//   FRAME_BITS        - width of an assembled frame
//   framer_state_t    - UNSYNC / SYNC framer states
package orbtrace_pkg;

  localparam logic [31:0] SYNC_PATTERN      = 32'h7FFF_FFFF;
  localparam int          NIBBLES_PER_FRAME = 32;
  localparam int          FRAME_BITS        = 128;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } framer_state_t;

endpackage

// File: rtl/trace_sync_detect.sv
// rtl/trace_sync_detect.sv - 32-bit nibble window and TPIU sync comparator
//
// Purpose: shifts each valid nibble into a 32-bit window (new nibble at
// [31:28], older nibbles toward bit 0) and flags when the window, including
// the nibble arriving this cycle, equals the sync pattern.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset, clears the window
//   din      - trace nibble
//   dinValid - din holds a new nibble this cycle
//   match    - combinational: the nibble arriving now completes a sync
module trace_sync_detect
  import orbtrace_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       dinValid,
  output logic       match
);

  logic [31:0] window;
  logic [31:0] window_next;

  assign window_next = {din, window[31:4]};

  // Compare against the post-shift value so the framer can react to the
  // match nibble itself and keep it out of the frame data.
  assign match = dinValid && (window_next == SYNC_PATTERN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
    end else if (dinValid) begin
      window <= window_next;
    end
  end

endmodule

// File: rtl/trace_framer.sv
// rtl/trace_framer.sv - TPIU trace nibble stream to 128-bit frame assembler
//
// Purpose: aligns to the TPIU sync pattern, assembles 32 nibbles per frame
// (nibble k at bits [4k+3:4k]) and hands frames out through a single holding
// register with valid/ready handshake. Optionally drops sync after
// SYNC_TIMEOUT frames without a fresh sync (0 = never).
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   din        - trace nibble
//   dinValid   - din holds a new nibble this cycle
//   frame      - assembled frame (holding register)
//   frameValid - frame holds an undelivered frame
//   frameReady - downstream accepts frame when frameValid is also high
//   synced     - framer is aligned (SYNC state)
//   syncPulse  - one-cycle pulse after each sync match
//   ovfPulse   - one-cycle pulse when a completed frame is dropped
module trace_framer
  import orbtrace_pkg::*;
#(
  parameter int SYNC_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            din,
  input  logic                  dinValid,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frameValid,
  input  logic                  frameReady,
  output logic                  synced,
  output logic                  syncPulse,
  output logic                  ovfPulse
);

  localparam logic [4:0]  LAST_NIB = 5'(NIBBLES_PER_FRAME - 1);
  localparam logic [15:0] TO_LIMIT = 16'(SYNC_TIMEOUT);

  framer_state_t state, state_next;

  logic                  sync_match;
  logic [4:0]            nib_cnt;
  logic [15:0]           to_cnt;
  logic [FRAME_BITS-1:0] asm_buf;
  logic                  data_nib;
  logic                  frame_done;
  logic                  timeout_hit;
  logic                  take_frame;

  trace_sync_detect u_sync_detect (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .dinValid (dinValid),
    .match    (sync_match)
  );

  // A nibble is frame data only when synced and it is not the sync's own
  // terminating nibble.
  assign data_nib    = dinValid && (state == ST_SYNC) && !sync_match;
  assign frame_done  = data_nib && (nib_cnt == LAST_NIB);
  assign timeout_hit = frame_done && (TO_LIMIT != 16'd0) && (to_cnt == TO_LIMIT - 16'd1);
  // Holding register can take the new frame if empty or emptying this cycle.
  assign take_frame  = frame_done && (!frameValid || frameReady);

  assign synced = (state == ST_SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_UNSYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (sync_match) begin
      state_next = ST_SYNC;
    end else if (timeout_hit) begin
      state_next = ST_UNSYNC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_cnt    <= '0;
      to_cnt     <= '0;
      asm_buf    <= '0;
      frame      <= '0;
      frameValid <= 1'b0;
      syncPulse  <= 1'b0;
      ovfPulse   <= 1'b0;
    end else begin
      syncPulse <= sync_match;
      ovfPulse  <= frame_done && !take_frame;

      if (sync_match) begin
        nib_cnt <= '0;
        to_cnt  <= '0;
        asm_buf <= '0;
      end else if (data_nib) begin
        asm_buf[{nib_cnt, 2'b00} +: 4] <= din;
        // Wraps to 0 after the last nibble, so collection continues seamlessly.
        nib_cnt <= nib_cnt + 5'd1;
        if (frame_done) begin
          to_cnt <= timeout_hit ? 16'd0 : to_cnt + 16'd1;
        end
      end

      if (take_frame) begin
        frame      <= {din, asm_buf[FRAME_BITS-5:0]};
        frameValid <= 1'b1;
      end else if (frameValid && frameReady) begin
        frameValid <= 1'b0;
      end
    end
  end

endmodule
